oreg_acc_bank: RTL and testbench

- Multi-channel output register bank for the PE array.
- Captures N_CH signed results per write into a DEPTH-entry buffer per channel.
- Each write either overwrites an entry or accumulates into it, so partial sums from several filter/tile passes can be combined.
- On request, drains all entries in order over a valid/ready interface, saturated to the data width, toward the output writer.

---
 rtl/oreg_pkg.sv | 56 +++++
 rtl/oreg_chan.sv | 57 +++++
 rtl/oreg_acc_bank.sv | 134 +++++++++++++
 tb/tb_oreg_acc_bank.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oreg_pkg.sv
// Shared types and helpers for the output register bank.
// Latency: n/a (types, width helpers and pure functions only).
// Backpressure: n/a.
package oreg_pkg;

   // Drain FSM: FILL accepts writes, DRAIN streams entries out.
   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   localparam int DEF_F_WIDTH = 8;
   localparam int DEF_I_WIDTH = 8;
   localparam int DEF_N_CH    = 4;
   localparam int DEF_DEPTH   = 8;
   localparam int DEF_GUARD   = 4;

   // Data word width from fractional and integer bit counts.
   function automatic int dw_of(input int f_width, input int i_width);
      return f_width + i_width;
   endfunction

   // Accumulator width: data word plus guard bits.
   function automatic int acc_w_of(input int dw, input int guard);
      return dw + guard;
   endfunction

   // Pointer width able to index DEPTH entries.
   function automatic int ptr_w_of(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   // Clamp a value into the signed range of a w-bit word (w <= 62).
   function automatic logic signed [63:0] clamp(input logic signed [63:0] a,
                                                 input int                 w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (a > hi) begin
         return hi;
      end else if (a < lo) begin
         return lo;
      end
      return a;
   endfunction

   // Add two w-bit signed values, saturating instead of wrapping. Both
   // operands arrive sign-extended to 64 bits, so the raw sum cannot overflow.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int                 w);
      return clamp(a + b, w);
   endfunction

endpackage

// File: rtl/oreg_chan.sv
// One channel of the output bank: DEPTH x ACC_W entries, overwrite/accumulate update, clamped read.
// Latency: write lands in the entry at the next edge; read is a combinational mux of the entry.
// Backpressure: none here; the top gates wr_en_i and sequences rd_ptr_i.
// Ports: clk_i/rst_n_i clock and async reset; clr_i synchronous clear of all entries
//   (wins over a write); wr_en_i/acc_mode_i/wr_ptr_i/wr_data_i write port;
//   rd_ptr_i/rd_data_o clamped read port.
module oreg_chan
   import oreg_pkg::*;
#(
   parameter int DW    = 16,
   parameter int ACC_W = 20,
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             clr_i,
   input  logic             wr_en_i,
   input  logic             acc_mode_i,
   input  logic [PTR_W-1:0] wr_ptr_i,
   input  logic [DW-1:0]    wr_data_i,
   input  logic [PTR_W-1:0] rd_ptr_i,
   output logic [DW-1:0]    rd_data_o
);

   logic signed [ACC_W-1:0] mem_q [DEPTH];
   logic signed [ACC_W-1:0] mem_d [DEPTH];
   logic signed [ACC_W-1:0] wr_ext;
   logic signed [ACC_W-1:0] acc_sum;

   always_comb begin
      mem_d   = mem_q;
      wr_ext  = {{(ACC_W - DW){wr_data_i[DW-1]}}, wr_data_i};
      acc_sum = ACC_W'(sat_add(64'(mem_q[wr_ptr_i]), 64'(wr_ext), ACC_W));
      if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
         end
      end else if (wr_en_i) begin
         mem_d[wr_ptr_i] = acc_mode_i ? acc_sum : wr_ext;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Guard bits let partial sums exceed the word range; clamp only on the way out.
   assign rd_data_o = DW'(clamp(64'(mem_q[rd_ptr_i]), DW));

endmodule

// File: rtl/oreg_acc_bank.sv
// Multi-channel output register bank: N_CH channels of DEPTH entries, overwrite or accumulate, drained in order.
// Latency: write to stored entry 1 cycle; drain_start_i to first rd_valid_o 1 cycle; full drain DEPTH beats.
// Backpressure: rd_ready_i low holds rd_ptr and rd_data_o stable; writes during a drain are dropped and set err_o.
// Ports: clk_i/rst_n_i clock and async reset; clr_i synchronous clear; wr_en_i/acc_mode_i/wr_data_i
//   lockstep write; drain_start_i starts a drain; rd_valid_o/rd_ready_i/rd_data_o/rd_last_o drain
//   stream; busy_o high in DRAIN; err_o sticky illegal-write flag.
module oreg_acc_bank
   import oreg_pkg::*;
#(
   parameter int  F_WIDTH = DEF_F_WIDTH,
   parameter int  I_WIDTH = DEF_I_WIDTH,
   parameter int  N_CH    = DEF_N_CH,
   parameter int  DEPTH   = DEF_DEPTH,
   parameter int  GUARD   = DEF_GUARD,
   localparam int DW      = dw_of(F_WIDTH, I_WIDTH),
   localparam int ACC_W   = acc_w_of(DW, GUARD),
   localparam int PTR_W   = ptr_w_of(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              clr_i,
   input  logic              wr_en_i,
   input  logic              acc_mode_i,
   input  logic [N_CH*DW-1:0] wr_data_i,
   input  logic              drain_start_i,
   input  logic              rd_ready_i,
   output logic              rd_valid_o,
   output logic [N_CH*DW-1:0] rd_data_o,
   output logic              rd_last_o,
   output logic              busy_o,
   output logic              err_o
);

   state_t           state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             err_q, err_d;
   logic             chan_wr;
   logic             chan_clr;
   logic             in_drain;
   logic             at_last;
   logic [DW-1:0]    chan_rd [N_CH];

   assign in_drain = (state_q == ST_DRAIN);
   assign at_last  = (rd_ptr_q == PTR_W'(DEPTH - 1));

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      err_d    = err_q;
      chan_wr  = 1'b0;
      chan_clr = 1'b0;
      if (clr_i) begin
         state_d  = ST_FILL;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         err_d    = 1'b0;
         chan_clr = 1'b1;
      end else begin
         case (state_q)
            ST_FILL: begin
               if (wr_en_i) begin
                  chan_wr  = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
               end
               // A same-cycle write still lands; the drain always starts at
               // entry 0 and covers every entry, even after a partial pass.
               if (drain_start_i) begin
                  state_d  = ST_DRAIN;
                  rd_ptr_d = '0;
                  wr_ptr_d = '0;
               end
            end
            ST_DRAIN: begin
               if (wr_en_i) begin
                  err_d = 1'b1;
               end
               if (rd_ready_i) begin
                  if (at_last) begin
                     // Zero the bank so the next pass can accumulate from scratch.
                     state_d  = ST_FILL;
                     rd_ptr_d = '0;
                     chan_clr = 1'b1;
                  end else begin
                     rd_ptr_d = rd_ptr_q + PTR_W'(1);
                  end
               end
            end
            default: state_d = ST_FILL;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_FILL;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_chan
      oreg_chan #(
         .DW    (DW),
         .ACC_W (ACC_W),
         .DEPTH (DEPTH),
         .PTR_W (PTR_W)
      ) u_chan (
         .clk_i      (clk_i),
         .rst_n_i    (rst_n_i),
         .clr_i      (chan_clr),
         .wr_en_i    (chan_wr),
         .acc_mode_i (acc_mode_i),
         .wr_ptr_i   (wr_ptr_q),
         .wr_data_i  (wr_data_i[k*DW +: DW]),
         .rd_ptr_i   (rd_ptr_q),
         .rd_data_o  (chan_rd[k])
      );
      assign rd_data_o[k*DW +: DW] = in_drain ? chan_rd[k] : '0;
   end

   assign rd_valid_o = in_drain;
   assign busy_o     = in_drain;
   assign rd_last_o  = in_drain & at_last;
   assign err_o      = err_q;

endmodule

// File: tb/tb_oreg_acc_bank.sv
module tb_oreg_acc_bank;

   localparam int NC = 4;
   localparam int DP = 8;
   localparam int W  = 16;
   localparam int ACC_MAX = (1 << 19) - 1;
   localparam int ACC_MIN = -(1 << 19);

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            clr = 1'b0;
   logic            wr_en = 1'b0;
   logic            acc_mode = 1'b0;
   logic [NC*W-1:0] wr_data = '0;
   logic            drain_start = 1'b0;
   logic            rd_ready = 1'b0;
   logic            rd_valid;
   logic [NC*W-1:0] rd_data;
   logic            rd_last;
   logic            busy;
   logic            err;

   oreg_acc_bank dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .clr_i         (clr),
      .wr_en_i       (wr_en),
      .acc_mode_i    (acc_mode),
      .wr_data_i     (wr_data),
      .drain_start_i (drain_start),
      .rd_ready_i    (rd_ready),
      .rd_valid_o    (rd_valid),
      .rd_data_o     (rd_data),
      .rd_last_o     (rd_last),
      .busy_o        (busy),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: the bank as plain integer arrays plus a drain flag.
   int m_mem [NC][DP];
   int m_wp;
   int m_rp;
   bit m_dr;
   bit m_err;

   typedef struct {
      bit wr;
      bit acc;
      bit ds;
      bit rdy;
      int d0;
      bit e_vld;
      bit e_last;
      bit e_err;
      int e_d0;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ch(input int k);
      logic signed [W-1:0] t;
      t = rd_data[k*W +: W];
      return int'(t);
   endfunction

   function automatic logic [NC*W-1:0] pk(input int a, input int b, input int c, input int d);
      return {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
   endfunction

   function automatic int word_of(input logic [NC*W-1:0] d, input int k);
      logic signed [W-1:0] t;
      t = d[k*W +: W];
      return int'(t);
   endfunction

   function automatic int clamp16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NC; k++)
         for (int e = 0; e < DP; e++)
            m_mem[k][e] = 0;
      m_wp = 0;
      m_rp = 0;
      m_dr = 0;
      m_err = 0;
   endtask

   task automatic model_check();
      chk("rd_valid", rd_valid, m_dr);
      chk("busy", busy, m_dr);
      chk("rd_last", rd_last, m_dr && m_rp == DP - 1);
      chk("err", err, m_err);
      for (int k = 0; k < NC; k++)
         chk($sformatf("rd_data_ch%0d", k), ch(k), m_dr ? clamp16(m_mem[k][m_rp]) : 0);
   endtask

   task automatic model_step(input bit w, input bit a, input logic [NC*W-1:0] d,
                             input bit ds, input bit rdy, input bit c);
      if (c) begin
         model_reset();
      end else if (!m_dr) begin
         if (w) begin
            for (int k = 0; k < NC; k++) begin
               int v;
               v = word_of(d, k);
               if (a) begin
                  v = v + m_mem[k][m_wp];
                  if (v > ACC_MAX) v = ACC_MAX;
                  if (v < ACC_MIN) v = ACC_MIN;
               end
               m_mem[k][m_wp] = v;
            end
            m_wp = (m_wp + 1) % DP;
         end
         if (ds) begin
            m_dr = 1;
            m_rp = 0;
            m_wp = 0;
         end
      end else begin
         if (w) m_err = 1;
         if (rdy) begin
            if (m_rp == DP - 1) begin
               for (int k = 0; k < NC; k++)
                  for (int e = 0; e < DP; e++)
                     m_mem[k][e] = 0;
               m_dr = 0;
               m_rp = 0;
            end else begin
               m_rp++;
            end
         end
      end
   endtask

   // Called at a falling edge: drive, check current outputs, advance the model,
   // and return at the next falling edge.
   task automatic tick(input bit w, input bit a, input logic [NC*W-1:0] d,
                       input bit ds, input bit rdy, input bit c);
      wr_en = w;
      acc_mode = a;
      wr_data = d;
      drain_start = ds;
      rd_ready = rdy;
      clr = c;
      model_check();
      model_step(w, a, d, ds, rdy, c);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      tick(0, 0, '0, 0, 0, 0);
   endtask

   task automatic do_clr();
      tick(0, 0, '0, 0, 0, 1);
   endtask

   task automatic finish_drain();
      for (int i = 0; i < 2 * DP && m_dr; i++)
         tick(0, 0, '0, 0, 1, 0);
   endtask

   initial begin
      // Table: expected outputs are those seen before the row's inputs apply.
      tbl[0] = '{wr:1, acc:0, ds:0, rdy:0, d0:5,  e_vld:0, e_last:0, e_err:0, e_d0:0};
      tbl[1] = '{wr:1, acc:1, ds:0, rdy:0, d0:5,  e_vld:0, e_last:0, e_err:0, e_d0:0};
      tbl[2] = '{wr:0, acc:0, ds:1, rdy:0, d0:0,  e_vld:0, e_last:0, e_err:0, e_d0:0};
      tbl[3] = '{wr:1, acc:0, ds:0, rdy:0, d0:77, e_vld:1, e_last:0, e_err:0, e_d0:5};
      tbl[4] = '{wr:0, acc:0, ds:0, rdy:1, d0:0,  e_vld:1, e_last:0, e_err:1, e_d0:5};
      tbl[5] = '{wr:0, acc:0, ds:0, rdy:1, d0:0,  e_vld:1, e_last:0, e_err:1, e_d0:5};
      tbl[6] = '{wr:0, acc:0, ds:0, rdy:1, d0:0,  e_vld:1, e_last:0, e_err:1, e_d0:0};

      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_valid", rd_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_err", err, 0);
      chk("reset_data", rd_data, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors
      do_clr();
      foreach (tbl[i]) begin
         chk($sformatf("tbl%0d_valid", i), rd_valid, tbl[i].e_vld);
         chk($sformatf("tbl%0d_last", i), rd_last, tbl[i].e_last);
         chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
         chk($sformatf("tbl%0d_d0", i), ch(0), tbl[i].e_d0);
         tick(tbl[i].wr, tbl[i].acc, pk(tbl[i].d0, 0, 0, 0), tbl[i].ds, tbl[i].rdy, 0);
      end
      finish_drain();

      // 1: overwrite and drain
      do_clr();
      for (int i = 0; i < DP; i++) tick(1, 0, pk(i + 1, 0, 0, -(i + 1)), 0, 0, 0);
      tick(0, 0, '0, 1, 1, 0);
      for (int b = 0; b < DP; b++) begin
         chk("t1_valid", rd_valid, 1);
         chk("t1_ch0", ch(0), b + 1);
         chk("t1_ch3", ch(3), -(b + 1));
         chk("t1_last", rd_last, b == DP - 1);
         tick(0, 0, '0, 0, 1, 0);
      end
      chk("t1_busy_after", busy, 0);

      // 2: accumulate across passes, then a drain of an empty bank
      do_clr();
      for (int i = 0; i < DP; i++) tick(1, 0, pk(100, 100, 100, 100), 0, 0, 0);
      for (int i = 0; i < DP; i++) tick(1, 1, pk(50, 50, 50, 50), 0, 0, 0);
      tick(0, 0, '0, 1, 0, 0);
      for (int b = 0; b < DP; b++) begin
         for (int k = 0; k < NC; k++) chk("t2_sum", ch(k), 150);
         tick(0, 0, '0, 0, 1, 0);
      end
      tick(0, 0, '0, 1, 0, 0);
      for (int b = 0; b < DP; b++) begin
         chk("t2_zero", rd_data, 0);
         tick(0, 0, '0, 0, 1, 0);
      end

      // 3: saturation through guard bits and output clamp
      do_clr();
      tick(1, 0, pk(0, 30000, -30000, 0), 0, 0, 0);
      for (int i = 1; i < DP; i++) tick(1, 0, '0, 0, 0, 0);
      tick(1, 1, pk(0, 30000, -30000, 0), 1, 0, 0);
      chk("t3_ch1", ch(1), 32767);
      chk("t3_ch2", ch(2), -32768);
      finish_drain();

      // 4: backpressure at beat 4
      do_clr();
      for (int i = 0; i < DP; i++) tick(1, 0, pk(10 + i, 0, 0, 0), 0, 0, 0);
      tick(0, 0, '0, 1, 0, 0);
      for (int b = 0; b < DP; b++) begin
         if (b == 3) begin
            for (int h = 0; h < 3; h++) begin
               chk("t4_hold_valid", rd_valid, 1);
               chk("t4_hold_ch0", ch(0), 13);
               tick(0, 0, '0, 0, 0, 0);
            end
         end
         chk("t4_order", ch(0), 10 + b);
         tick(0, 0, '0, 0, 1, 0);
      end
      chk("t4_done", busy, 0);

      // 5: illegal write during drain, then clr
      do_clr();
      for (int i = 0; i < DP; i++) tick(1, 0, pk(i + 1, 0, 0, 0), 0, 0, 0);
      tick(0, 0, '0, 1, 0, 0);
      tick(1, 0, pk(999, 999, 999, 999), 0, 0, 0);
      chk("t5_err_set", err, 1);
      chk("t5_data_kept", ch(0), 1);
      finish_drain();
      chk("t5_err_sticky", err, 1);
      do_clr();
      chk("t5_err_cleared", err, 0);

      // 5b: asynchronous reset at beat 5
      for (int i = 0; i < DP; i++) tick(1, 0, pk(20 + i, 1, 2, 3), 0, 0, 0);
      tick(0, 0, '0, 1, 0, 0);
      for (int b = 0; b < 4; b++) tick(0, 0, '0, 0, 1, 0);
      chk("t5_pre_reset_valid", rd_valid, 1);
      rd_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t5_reset_valid", rd_valid, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tick(0, 0, '0, 1, 0, 0);
      chk("t5_post_reset_zero", rd_data, 0);
      finish_drain();

      // 6: drain_start with a write to entry 7
      do_clr();
      for (int i = 0; i < DP - 1; i++) tick(1, 0, pk(1, 1, 1, 1), 0, 0, 0);
      tick(1, 0, pk(7, 7, 7, 7), 1, 0, 0);
      for (int b = 0; b < DP; b++) begin
         if (b == DP - 1) chk("t6_beat8", ch(0), 7);
         tick(0, 0, '0, 0, 1, 0);
      end

      // 6b: clr together with a write
      tick(1, 0, pk(55, 55, 55, 55), 0, 0, 1);
      tick(0, 0, '0, 1, 0, 0);
      for (int b = 0; b < DP; b++) begin
         chk("t6_clr_wins", rd_data, 0);
         tick(0, 0, '0, 0, 1, 0);
      end

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         logic [NC*W-1:0] d;
         for (int k = 0; k < NC; k++) begin
            int v;
            case ($urandom_range(0, 3))
               0: v = int'($urandom_range(0, 200)) - 100;
               1: v = 30000;
               2: v = -30000;
               default: v = int'($urandom_range(0, 65535)) - 32768;
            endcase
            d[k*W +: W] = v[W-1:0];
         end
         tick($urandom_range(0, 9) < 5, $urandom_range(0, 1) == 1, d,
              $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 99) < 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
